// File: rtl/euler_accum_bank.sv
// Bank of CHANNELS signed accumulators with a one-entry response buffer and sticky overflow flags.
// Define EULER_ACCUM_SATURATE_EN to clamp on ADD overflow instead of wrapping.
`timescale 1ns/1ps
module euler_accum_bank #(
  parameter int unsigned SIZE     = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CH_W     = 2
) (
  input  logic            clk,
  input  logic            rst_sync,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH_W-1:0] in_ch,
  input  logic [1:0]      in_op,
  input  logic [SIZE-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH_W-1:0] out_ch,
  output logic [SIZE-1:0] out_data,
  output logic            out_ovf,
  output logic            ovf_any
);

  typedef enum logic [1:0] {
    OpAdd   = 2'b00,
    OpLoad  = 2'b01,
    OpClear = 2'b10,
    OpRead  = 2'b11
  } op_e;

  localparam logic [SIZE-1:0] MaxVal = {1'b0, {(SIZE-1){1'b1}}};
  localparam logic [SIZE-1:0] MinVal = {1'b1, {(SIZE-1){1'b0}}};

  logic [SIZE-1:0]     acc_q [CHANNELS];
  logic [CHANNELS-1:0] ovf_q;

  logic            out_valid_q;
  logic [CH_W-1:0] out_ch_q;
  logic [SIZE-1:0] out_data_q;
  logic            out_ovf_q;
  logic            ovf_any_q;

  logic            accept;
  logic            hit;
  logic [SIZE-1:0] cur_acc;
  logic            cur_ovf;
  logic [SIZE-1:0] sum;
  logic            add_ovf;
  logic [SIZE-1:0] acc_d;
  logic            ovf_d;

  assign in_ready = ~rst_sync & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  // Channel select as a compare loop so out-of-range indices simply miss.
  always_comb begin
    hit     = 1'b0;
    cur_acc = '0;
    cur_ovf = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (32'(in_ch) == i) begin
        hit     = 1'b1;
        cur_acc = acc_q[i];
        cur_ovf = ovf_q[i];
      end
    end
  end

  assign sum     = cur_acc + in_data;
  assign add_ovf = (cur_acc[SIZE-1] == in_data[SIZE-1]) && (sum[SIZE-1] != cur_acc[SIZE-1]);

  always_comb begin
    acc_d = cur_acc;
    ovf_d = cur_ovf;
    case (op_e'(in_op))
      OpAdd: begin
        ovf_d = cur_ovf | add_ovf;
`ifdef EULER_ACCUM_SATURATE_EN
        if (add_ovf) begin
          acc_d = cur_acc[SIZE-1] ? MinVal : MaxVal;
        end else begin
          acc_d = sum;
        end
`else
        acc_d = sum;
`endif
      end
      OpLoad: begin
        acc_d = in_data;
        ovf_d = 1'b0;
      end
      OpClear: begin
        acc_d = '0;
        ovf_d = 1'b0;
      end
      OpRead: begin
        acc_d = cur_acc;
        ovf_d = cur_ovf;
      end
      default: begin
        acc_d = cur_acc;
        ovf_d = cur_ovf;
      end
    endcase
    // Unmapped channel: answer with zeros, touch nothing.
    if (!hit) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= '0;
      end
      ovf_q     <= '0;
      ovf_any_q <= 1'b0;
    end else begin
      if (accept) begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (32'(in_ch) == i) begin
            acc_q[i] <= acc_d;
            ovf_q[i] <= ovf_d;
          end
        end
      end
      ovf_any_q <= |ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_ch_q    <= in_ch;
      out_data_q  <= acc_d;
      out_ovf_q   <= ovf_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign ovf_any   = ovf_any_q;

endmodule

// File: tb/tb_euler_accum_bank.sv
// Bench for euler_accum_bank: a 4-channel and a 3-channel instance share one stimulus stream
// and are compared every cycle against an arithmetic reference model.
`timescale 1ns/1ps
module tb_euler_accum_bank;

  localparam logic [1:0] OpAdd   = 2'd0;
  localparam logic [1:0] OpLoad  = 2'd1;
  localparam logic [1:0] OpClear = 2'd2;
  localparam logic [1:0] OpRead  = 2'd3;

`ifdef EULER_ACCUM_SATURATE_EN
  localparam logic [15:0] ExpPosOvf = 16'h7FFF;
  localparam logic [15:0] ExpNegOvf = 16'h8000;
`else
  localparam logic [15:0] ExpPosOvf = 16'h8010;
  localparam logic [15:0] ExpNegOvf = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst_sync = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [1:0]  in_ch = '0;
  logic [1:0]  in_op = '0;
  logic [15:0] in_data = '0;

  logic        rdy4, v4, ovf4, any4;
  logic [1:0]  ch4;
  logic [15:0] d4;
  logic        rdy3, v3, ovf3, any3;
  logic [1:0]  ch3;
  logic [15:0] d3;

  always #5 clk = ~clk;

  euler_accum_bank #(.SIZE(16), .CHANNELS(4), .CH_W(2)) dut4 (
    .clk(clk), .rst_sync(rst_sync), .in_valid(in_valid), .in_ready(rdy4), .in_ch(in_ch),
    .in_op(in_op), .in_data(in_data), .out_valid(v4), .out_ready(out_ready), .out_ch(ch4),
    .out_data(d4), .out_ovf(ovf4), .ovf_any(any4)
  );

  euler_accum_bank #(.SIZE(16), .CHANNELS(3), .CH_W(2)) dut3 (
    .clk(clk), .rst_sync(rst_sync), .in_valid(in_valid), .in_ready(rdy3), .in_ch(in_ch),
    .in_op(in_op), .in_data(in_data), .out_valid(v3), .out_ready(out_ready), .out_ch(ch3),
    .out_data(d3), .out_ovf(ovf3), .ovf_any(any3)
  );

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] data;
    logic        ovf;
  } resp_t;

  resp_t       q4[$];
  resp_t       q3[$];
  logic [15:0] m_acc [2][4];
  bit          m_ovf [2][4];
  bit          any_prev [2];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on signed values, range test for overflow.
  task automatic model(input int k, input int n, input logic [1:0] op, input logic [1:0] ch,
                       input logic [15:0] d, output resp_t r);
    int a;
    int s;
    r.ch = ch;
    if (int'(ch) >= n) begin
      r.data = '0;
      r.ovf  = 1'b0;
      return;
    end
    case (op)
      OpAdd: begin
        a = $signed(m_acc[k][ch]);
        s = a + $signed(d);
        if (s > 32767 || s < -32768) begin
          m_ovf[k][ch] = 1'b1;
`ifdef EULER_ACCUM_SATURATE_EN
          s = (s > 0) ? 32767 : -32768;
`endif
        end
        m_acc[k][ch] = s[15:0];
      end
      OpLoad: begin
        m_acc[k][ch] = d;
        m_ovf[k][ch] = 1'b0;
      end
      OpClear: begin
        m_acc[k][ch] = '0;
        m_ovf[k][ch] = 1'b0;
      end
      default: ;
    endcase
    r.data = m_acc[k][ch];
    r.ovf  = m_ovf[k][ch];
  endtask

  // One clock: drive at negedge, check outputs against model, advance model for the next edge.
  task automatic cycle(input bit rst, input bit v, input logic [1:0] op, input logic [1:0] ch,
                       input logic [15:0] d, input bit ordy, output bit fired);
    bit    exp_rdy;
    resp_t r;
    @(negedge clk);
    rst_sync  = rst;
    in_valid  = v;
    in_op     = op;
    in_ch     = ch;
    in_data   = d;
    out_ready = ordy;
    #1;
    exp_rdy = !rst && (q4.size() == 0 || ordy);
    fired   = v && exp_rdy;
    if (chk_en) begin
      chk("in_ready", 32'(rdy4), 32'(exp_rdy));
      chk("in_ready3", 32'(rdy3), 32'(exp_rdy));
      chk("out_valid", 32'(v4), 32'(q4.size() > 0));
      chk("out_valid3", 32'(v3), 32'(q3.size() > 0));
      chk("ovf_any", 32'(any4), 32'(any_prev[0]));
      chk("ovf_any3", 32'(any3), 32'(any_prev[1]));
      if (q4.size() > 0) begin
        chk("out_ch", 32'(ch4), 32'(q4[0].ch));
        chk("out_data", 32'(d4), 32'(q4[0].data));
        chk("out_ovf", 32'(ovf4), 32'(q4[0].ovf));
      end
      if (q3.size() > 0) begin
        chk("out_ch3", 32'(ch3), 32'(q3[0].ch));
        chk("out_data3", 32'(d3), 32'(q3[0].data));
        chk("out_ovf3", 32'(ovf3), 32'(q3[0].ovf));
      end
    end
    if (q4.size() > 0 && ordy) void'(q4.pop_front());
    if (q3.size() > 0 && ordy) void'(q3.pop_front());
    for (int k = 0; k < 2; k++) begin
      any_prev[k] = 1'b0;
      for (int i = 0; i < 4; i++) any_prev[k] |= m_ovf[k][i];
    end
    if (fired) begin
      model(0, 4, op, ch, d, r);
      q4.push_back(r);
      model(1, 3, op, ch, d, r);
      q3.push_back(r);
    end
    if (rst) begin
      q4.delete();
      q3.delete();
      for (int k = 0; k < 2; k++) begin
        any_prev[k] = 1'b0;
        for (int i = 0; i < 4; i++) begin
          m_acc[k][i] = '0;
          m_ovf[k][i] = 1'b0;
        end
      end
    end
  endtask

  task automatic idle();
    bit f;
    cycle(1'b0, 1'b0, OpRead, 2'd0, 16'h0, 1'b1, f);
  endtask

  // Issue one command then one idle cycle; the response is left on the outputs.
  task automatic cmd(input logic [1:0] op, input logic [1:0] ch, input logic [15:0] d);
    bit f;
    cycle(1'b0, 1'b1, op, ch, d, 1'b1, f);
    chk("cmd_accepted", 32'(f), 32'd1);
    idle();
  endtask

  initial begin
    bit f;
    bit seen;
    int low;
    int idx;
    int nresp;
    bit ordy;
    logic [15:0] rd;

    cycle(1'b1, 1'b0, OpRead, 2'd0, 16'h0, 1'b1, f);
    chk_en = 1'b1;
    cycle(1'b1, 1'b1, OpLoad, 2'd0, 16'h1234, 1'b1, f);
    chk("rst_out_valid", 32'(v4), 32'd0);
    chk("rst_out_ch", 32'(ch4), 32'd0);
    chk("rst_out_data", 32'(d4), 32'd0);
    chk("rst_out_ovf", 32'(ovf4), 32'd0);
    chk("rst_ovf_any", 32'(any4), 32'd0);
    chk("rst_in_ready", 32'(rdy4), 32'd0);
    idle();

    // Basic load/add and untouched channels
    cmd(OpLoad, 2'd1, 16'h0100);
    chk("load_ch1", 32'(d4), 32'h0100);
    chk("load_ch1_ovf", 32'(ovf4), 32'd0);
    cmd(OpAdd, 2'd1, 16'h0023);
    chk("add_ch1", 32'(d4), 32'h0123);
    chk("add_ch1_ovf", 32'(ovf4), 32'd0);
    cmd(OpRead, 2'd0, 16'hFFFF);
    chk("read_ch0", 32'(d4), 32'h0);
    cmd(OpRead, 2'd2, 16'h0);
    chk("read_ch2", 32'(d4), 32'h0);
    cmd(OpRead, 2'd3, 16'h0);
    chk("read_ch3", 32'(d4), 32'h0);

    // Positive overflow, sticky flag, clear
    cmd(OpLoad, 2'd2, 16'h7FF0);
    cmd(OpAdd, 2'd2, 16'h0020);
    chk("pos_ovf_data", 32'(d4), 32'(ExpPosOvf));
    chk("pos_ovf_flag", 32'(ovf4), 32'd1);
    idle();
    chk("pos_ovf_any", 32'(any4), 32'd1);
    cmd(OpAdd, 2'd2, 16'hFFFF);
    chk("sticky_flag", 32'(ovf4), 32'd1);
    cmd(OpClear, 2'd2, 16'h5555);
    chk("clear_data", 32'(d4), 32'h0);
    chk("clear_flag", 32'(ovf4), 32'd0);
    idle();
    chk("clear_ovf_any", 32'(any4), 32'd0);

    // Negative overflow
    cmd(OpLoad, 2'd0, 16'h8000);
    cmd(OpAdd, 2'd0, 16'h8000);
    chk("neg_ovf_data", 32'(d4), 32'(ExpNegOvf));
    chk("neg_ovf_flag", 32'(ovf4), 32'd1);
    cmd(OpClear, 2'd0, 16'h0);

    // Unmapped channel on the 3-channel instance
    cmd(OpAdd, 2'd3, 16'h0005);
    chk("oob_data3", 32'(d3), 32'h0);
    chk("oob_ovf3", 32'(ovf3), 32'd0);
    chk("oob_ch3", 32'(ch3), 32'd3);
    chk("inrange_data4", 32'(d4), 32'h0005);
    for (int c = 0; c < 3; c++) cmd(OpRead, 2'(c), 16'h0);

    // Back-pressure: four ADD 1 to ch3, sink stalls 3 cycles after the first response
    cmd(OpClear, 2'd3, 16'h0);
    seen  = 1'b0;
    low   = 0;
    idx   = 0;
    nresp = 0;
    for (int c = 0; c < 40 && (idx < 4 || q4.size() > 0); c++) begin
      if (q4.size() > 0) seen = 1'b1;
      ordy = !(seen && low < 3);
      if (!ordy) low++;
      rd = 16'(nresp + 1);
      if (q4.size() > 0 && ordy) nresp++;
      cycle(1'b0, idx < 4, OpAdd, 2'd3, 16'h0001, ordy, f);
      if (!ordy) chk("bp_in_ready_low", 32'(rdy4), 32'd0);
      if (ordy && v4) chk("bp_order", 32'(d4), 32'(rd));
      if (f) idx++;
    end
    chk("bp_issued", 32'(idx), 32'd4);
    chk("bp_responses", 32'(nresp), 32'd4);
    idle();

    // Reset with a response pending
    cycle(1'b0, 1'b1, OpLoad, 2'd0, 16'h0055, 1'b0, f);
    cycle(1'b1, 1'b0, OpRead, 2'd0, 16'h0, 1'b0, f);
    chk("rst_pending_valid_before", 32'(v4), 32'd1);
    idle();
    chk("rst_drop_valid", 32'(v4), 32'd0);
    chk("rst_drop_data", 32'(d4), 32'h0);
    cmd(OpRead, 2'd0, 16'h0);
    chk("rst_ch0_cleared", 32'(d4), 32'h0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [15:0] dat;
      case ($urandom_range(0, 3))
        0: dat = 16'h7F00 | 16'($urandom_range(0, 255));
        1: dat = 16'h8000 | 16'($urandom_range(0, 255));
        default: dat = 16'($urandom);
      endcase
      cycle($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), dat, $urandom_range(0, 3) != 0, f);
    end
    for (int n = 0; n < 3; n++) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
